// File: rtl/itof_arbiter_if.sv
// -----------------------------------------------------------------------------
// itof_arbiter_if
//   Request/response handshake bundle for the two requesters that share one
//   itof converter through itof_arbiter.
//   reqN_valid/reqN_ready/reqN_op       : operand request port of requester N
//   respN_valid/respN_ready/respN_result: float32 result port of requester N
//   master : requester side (drives requests, consumes responses)
//   slave  : arbiter side
// -----------------------------------------------------------------------------
interface itof_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_op;
  logic        resp0_valid;
  logic        resp0_ready;
  logic [31:0] resp0_result;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_op;
  logic        resp1_valid;
  logic        resp1_ready;
  logic [31:0] resp1_result;

  modport master (
    output req0_valid, req0_op, resp0_ready,
    output req1_valid, req1_op, resp1_ready,
    input  req0_ready, resp0_valid, resp0_result,
    input  req1_ready, resp1_valid, resp1_result
  );

  modport slave (
    input  req0_valid, req0_op, resp0_ready,
    input  req1_valid, req1_op, resp1_ready,
    output req0_ready, resp0_valid, resp0_result,
    output req1_ready, resp1_valid, resp1_result
  );
endinterface

// File: rtl/itof_arbiter.sv
// -----------------------------------------------------------------------------
// itof_arbiter
//   Shares one non-stallable pipelined int-to-float converter between two
//   requesters. Round-robin picks at most one operand per cycle, a tag pipe of
//   LATENCY stages follows each operand through the converter, and the result
//   is steered into the owning requester's FIFO. Issue is gated by per-requester
//   credit (FIFO slots minus occupancy minus in-flight), so every result that
//   leaves the converter is guaranteed a slot.
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset
//   bus         : requester handshakes (itof_arbiter_if.slave)
//   unit_op     : operand to the converter (0 when nothing is issued)
//   unit_result : converter output, LATENCY cycles after unit_op
//   idle        : nothing in flight and both FIFOs empty
// -----------------------------------------------------------------------------
module itof_arbiter #(
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  itof_arbiter_if.slave       bus,
  output logic [31:0]         unit_op,
  input  logic [31:0]         unit_result,
  output logic                idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [5:0] DEPTH_C = 6'(FIFO_DEPTH);

  logic [LATENCY-1:0] r_tag_vld;
  logic [LATENCY-1:0] r_tag_id;
  logic               r_last;
  logic [AW-1:0]      r_wp  [2];
  logic [AW-1:0]      r_rp  [2];
  logic [CW-1:0]      r_cnt [2];
  logic [31:0]        r_mem [2][FIFO_DEPTH];

  logic [5:0] w_infl0, w_infl1;
  logic       w_cred0, w_cred1;
  logic       w_elig0, w_elig1;
  logic       w_g0, w_g1, w_issue;
  logic [1:0] w_push, w_pop;

  // Per-requester count of valid tag stages (work inside the converter).
  always_comb begin
    w_infl0 = '0;
    w_infl1 = '0;
    for (int i = 0; i < LATENCY; i++) begin
      w_infl0 = w_infl0 + 6'(r_tag_vld[i] & ~r_tag_id[i]);
      w_infl1 = w_infl1 + 6'(r_tag_vld[i] &  r_tag_id[i]);
    end
  end

  // credit_N > 0  <=>  occupancy + in-flight < depth
  assign w_cred0 = (6'(r_cnt[0]) + w_infl0) < DEPTH_C;
  assign w_cred1 = (6'(r_cnt[1]) + w_infl1) < DEPTH_C;
  assign w_elig0 = bus.req0_valid & w_cred0;
  assign w_elig1 = bus.req1_valid & w_cred1;

  // r_last == 1 means requester 1 was granted last, so requester 0 wins a tie.
  // Grants are blocked while reset is held so nothing is presented to the unit.
  assign w_g0    = reset & w_elig0 & (~w_elig1 |  r_last);
  assign w_g1    = reset & w_elig1 & (~w_elig0 | ~r_last);
  assign w_issue = w_g0 | w_g1;

  // Ready ignores the own valid: only credit and whether the other side would
  // win the tie matter.
  assign bus.req0_ready = w_cred0 & ~(w_elig1 & ~r_last);
  assign bus.req1_ready = w_cred1 & ~(w_elig0 &  r_last);

  assign unit_op = w_g0 ? bus.req0_op : (w_g1 ? bus.req1_op : 32'd0);

  assign w_push[0] = r_tag_vld[LATENCY-1] & ~r_tag_id[LATENCY-1];
  assign w_push[1] = r_tag_vld[LATENCY-1] &  r_tag_id[LATENCY-1];
  assign w_pop[0]  = bus.resp0_ready & (r_cnt[0] != '0);
  assign w_pop[1]  = bus.resp1_ready & (r_cnt[1] != '0);

  // Issue stage -> tag pipe stage 0; last tag stage -> FIFO write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
      r_last    <= 1'b1;
      for (int n = 0; n < 2; n++) begin
        r_wp[n]  <= '0;
        r_rp[n]  <= '0;
        r_cnt[n] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_issue;
      r_tag_id[0]  <= w_g1;
      for (int i = 1; i < LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
      if (w_issue) r_last <= w_g1;
      for (int n = 0; n < 2; n++) begin
        if (w_push[n]) r_wp[n] <= r_wp[n] + AW'(1);
        if (w_pop[n])  r_rp[n] <= r_rp[n] + AW'(1);
        r_cnt[n] <= r_cnt[n] + CW'(w_push[n]) - CW'(w_pop[n]);
      end
    end
  end

  // FIFO storage: data only, no reset.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (w_push[n]) r_mem[n][r_wp[n]] <= unit_result;
    end
  end

  assign bus.resp0_valid  = (r_cnt[0] != '0);
  assign bus.resp1_valid  = (r_cnt[1] != '0);
  assign bus.resp0_result = r_mem[0][r_rp[0]];
  assign bus.resp1_result = r_mem[1][r_rp[1]];

  assign idle = ~(|r_tag_vld) & (r_cnt[0] == '0) & (r_cnt[1] == '0);

endmodule

// File: tb/tb_itof_arbiter.sv
`timescale 1ns/1ps
module tb_itof_arbiter;
  localparam int LATENCY    = 2;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] unit_op;
  logic [31:0] unit_result;
  logic        idle;
  itof_arbiter_if bus();

  itof_arbiter #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .unit_op(unit_op), .unit_result(unit_result), .idle(idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference int32 -> float32 (round to nearest even) via exact double.
  function automatic logic [31:0] ref_itof(input logic [31:0] x);
    real         r;
    logic [63:0] b;
    logic [24:0] m;
    int          e8;
    if (x == 32'd0) return 32'd0;
    r  = real'($signed(x));
    b  = $realtobits(r);
    m  = {2'b01, b[51:29]};
    e8 = int'(b[62:52]) - 1023 + 127;
    if (b[28] && ((|b[27:0]) || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m  = m >> 1;
      e8 = e8 + 1;
    end
    return {b[63], 8'(e8), m[22:0]};
  endfunction

  // Behavioural converter: non-stallable LATENCY-deep pipeline.
  logic [31:0] upipe [LATENCY];
  always @(posedge clk) begin
    upipe[0] <= ref_itof(unit_op);
    for (int i = 1; i < LATENCY; i++) upipe[i] <= upipe[i-1];
  end
  assign unit_result = upipe[LATENCY-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each queue holds accepted, not-yet-consumed results of one
  // requester, with the edge at which the operand was accepted.
  typedef struct { logic [31:0] val; int acc; } ent_t;
  ent_t        q0[$], q1[$];
  logic [31:0] log0[$], log1[$];
  logic        m_last = 1'b1;

  always @(negedge clk) begin
    logic c0, c1, e0, e1, g0, g1, ev0, ev1;
    logic [31:0] eop;
    if (!reset) begin
      q0.delete(); q1.delete();
      m_last = 1'b1;
      chk("rst_resp0_valid", bus.resp0_valid, 0);
      chk("rst_resp1_valid", bus.resp1_valid, 0);
      chk("rst_idle", idle, 1);
      chk("rst_unit_op", unit_op, 0);
      chk("rst_req0_ready", bus.req0_ready, 1);
      chk("rst_req1_ready", bus.req1_ready, !bus.req0_valid);
    end else begin
      c0  = q0.size() < FIFO_DEPTH;
      c1  = q1.size() < FIFO_DEPTH;
      e0  = bus.req0_valid && c0;
      e1  = bus.req1_valid && c1;
      g0  = e0 && (!e1 || m_last);
      g1  = e1 && (!e0 || !m_last);
      eop = g0 ? bus.req0_op : (g1 ? bus.req1_op : 32'd0);
      ev0 = q0.size() > 0 && cyc >= q0[0].acc + LATENCY;
      ev1 = q1.size() > 0 && cyc >= q1[0].acc + LATENCY;
      chk("req0_ready", bus.req0_ready, c0 && !(e1 && !m_last));
      chk("req1_ready", bus.req1_ready, c1 && !(e0 && m_last));
      chk("unit_op", unit_op, eop);
      chk("idle", idle, q0.size() == 0 && q1.size() == 0);
      chk("resp0_valid", bus.resp0_valid, ev0);
      chk("resp1_valid", bus.resp1_valid, ev1);
      if (ev0) chk("resp0_data", bus.resp0_result, q0[0].val);
      if (ev1) chk("resp1_data", bus.resp1_result, q1[0].val);
      if (ev0 && bus.resp0_ready) begin
        log0.push_back(bus.resp0_result);
        void'(q0.pop_front());
      end
      if (ev1 && bus.resp1_ready) begin
        log1.push_back(bus.resp1_result);
        void'(q1.pop_front());
      end
      if (g0) begin
        q0.push_back('{ref_itof(bus.req0_op), cyc + 1});
        m_last = 1'b0;
      end else if (g1) begin
        q1.push_back('{ref_itof(bus.req1_op), cyc + 1});
        m_last = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (idle) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, seen, 1);
  endtask

  initial begin
    int          lat, acc1, sent, bad;
    int          gs[6];
    logic [31:0] tx[$];

    reset = 1'b0;
    bus.req0_valid = 0; bus.req0_op = 0; bus.resp0_ready = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.resp1_ready = 0;

    // Reset state, including ready behaviour while reset is held
    repeat (2) @(negedge clk);
    chk("reset_idle", idle, 1);
    chk("reset_unit_op", unit_op, 0);
    bus.req0_valid = 1; bus.req1_valid = 1;
    #1;
    chk("reset_tie_ready0", bus.req0_ready, 1);
    chk("reset_tie_ready1", bus.req1_ready, 0);
    chk("reset_tie_unit_op", unit_op, 0);
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick();
    reset = 1'b1;

    // Single issue
    bus.resp0_ready = 1; bus.req0_op = 32'd1; bus.req0_valid = 1;
    @(negedge clk);
    chk("single_ready", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.resp0_valid) begin
        lat = k;
        break;
      end
    end
    chk("single_latency", lat, LATENCY + 1);
    chk("single_result", bus.resp0_result, 32'h3F800000);
    chk("single_resp1_quiet", bus.resp1_valid, 0);
    wait_idle("single_drain");

    // Tie alternation right after reset
    tick(); reset = 1'b0; tick(); reset = 1'b1;
    log0.delete(); log1.delete();
    bus.resp0_ready = 1; bus.resp1_ready = 1;
    bus.req0_op = 32'd0; bus.req1_op = 32'hFFFFFFFF;
    bus.req0_valid = 1; bus.req1_valid = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      gs[i] = bus.req1_ready ? 1 : 0;
      tick();
      if (gs[i] == 0) bus.req0_op = bus.req0_op + 32'd2;
      else            bus.req1_op = bus.req1_op - 32'd1;
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    for (int i = 0; i < 6; i++) chk("tie_grant_order", gs[i], i % 2);
    wait_idle("tie_drain");
    chk("tie_rx0_count", log0.size(), 3);
    chk("tie_rx1_count", log1.size(), 3);
    chk("tie_rx0_0", log0[0], 32'h00000000);
    chk("tie_rx0_1", log0[1], 32'h40000000);
    chk("tie_rx0_2", log0[2], 32'h40800000);
    chk("tie_rx1_0", log1[0], 32'hBF800000);
    chk("tie_rx1_1", log1[1], 32'hC0000000);
    chk("tie_rx1_2", log1[2], 32'hC0400000);

    // Backpressure on requester 1
    tick();
    bus.resp1_ready = 0; bus.resp0_ready = 1;
    bus.req1_valid = 1; bus.req1_op = $urandom;
    acc1 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.req1_ready) acc1++;
      tick();
      bus.req1_op = $urandom;
    end
    chk("bp_accepted", acc1, FIFO_DEPTH);
    @(negedge clk);
    chk("bp_ready1_low", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1; bus.req0_op = $urandom;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("bp_req0_granted", bus.req0_ready, 1);
      tick();
      bus.req0_op = $urandom;
    end
    bus.req0_valid = 0; bus.resp1_ready = 1;
    @(negedge clk);
    chk("bp_ready1_before_pop", bus.req1_ready, 0);
    tick();
    bus.resp1_ready = 0;
    @(negedge clk);
    chk("bp_ready1_after_pop", bus.req1_ready, 1);
    tick();
    @(negedge clk);
    chk("bp_ready1_refilled", bus.req1_ready, 0);
    tick();
    bus.req1_valid = 0; bus.resp1_ready = 1;
    wait_idle("bp_drain");

    // Fill FIFO 0, then stream 100 operands with the consumer always ready
    tick();
    log0.delete();
    bus.resp0_ready = 0; bus.req0_valid = 1; bus.req0_op = $urandom;
    sent = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.req0_ready) begin
        tx.push_back(bus.req0_op);
        sent++;
      end
      tick();
      bus.req0_op = $urandom;
      if (i == 8) bus.resp0_ready = 1;
      if (sent == 100) begin
        bus.req0_valid = 0;
        break;
      end
    end
    chk("stream_sent", sent, 100);
    wait_idle("stream_drain");
    chk("stream_rx_count", log0.size(), 100);
    bad = 0;
    for (int i = 0; i < 100; i++) if (log0[i] !== ref_itof(tx[i])) bad++;
    chk("stream_order", bad, 0);

    // Reset with 3 results buffered (req 0) and 2 in flight (req 1)
    tick();
    bus.resp0_ready = 0; bus.resp1_ready = 0;
    bus.req0_valid = 1; bus.req0_op = $urandom;
    tick(); bus.req0_op = $urandom;
    tick(); bus.req0_op = $urandom;
    tick();
    bus.req0_valid = 0; bus.req1_valid = 1; bus.req1_op = $urandom;
    tick(); bus.req1_op = $urandom;
    tick();
    chk("mid_buffered", bus.resp0_valid, 1);
    chk("mid_busy", idle, 0);
    reset = 1'b0; bus.req1_valid = 0;
    #1;
    chk("mid_rst_resp0", bus.resp0_valid, 0);
    chk("mid_rst_resp1", bus.resp1_valid, 0);
    chk("mid_rst_idle", idle, 1);
    tick(); tick();
    reset = 1'b1;
    bus.resp0_ready = 1; bus.resp1_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale0", bus.resp0_valid, 0);
      chk("post_rst_no_stale1", bus.resp1_valid, 0);
    end
    tick();
    bus.req0_valid = 1; bus.req1_valid = 1;
    bus.req0_op = $urandom; bus.req1_op = $urandom;
    @(negedge clk);
    chk("post_rst_tie0", bus.req0_ready, 1);
    chk("post_rst_tie1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 0; bus.req1_valid = 0;
    wait_idle("post_rst_drain");

    // Random soak; the scoreboard checks every cycle
    for (int i = 0; i < 10000; i++) begin
      tick();
      bus.req0_valid  = ($urandom_range(0, 3) != 0);
      bus.req1_valid  = ($urandom_range(0, 2) != 0);
      bus.req0_op     = $urandom;
      bus.req1_op     = $urandom;
      bus.resp0_ready = ($urandom_range(0, 1) != 0);
      bus.resp1_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.resp0_ready = 1; bus.resp1_ready = 1;
    wait_idle("soak_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
